// File: rtl/bit_packer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bit_packer_pkg
//  Purpose  : Shared definitions for the bit_packer serial-to-parallel block:
//             output-register state encoding, drop-counter ceiling and the
//             word parity helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bit_packer_pkg;

    // Occupancy of the single-entry output register.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // drop_count saturates here rather than wrapping back to zero.
    localparam logic [7:0] DROP_MAX = 8'd255;

    // Even/odd parity of a word. Callers zero-extend narrower words, which
    // leaves the XOR unchanged.
    function automatic logic parity_of(input logic [31:0] word);
        return ^word;
    endfunction

endpackage : bit_packer_pkg
`default_nettype wire

// File: rtl/bit_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bit_packer
//  Purpose  : Packs a 1-bit qualified serial stream into WIDTH-bit words and
//             presents each word with its parity on a valid/ready port.
//             The serial side cannot be stalled, so a word that completes
//             while the output register is still occupied (and not being
//             accepted) is dropped, flagged via overflow and counted.
//  Params   : WIDTH     - bits per word (2..32)
//             MSB_FIRST - 1: first bit lands in word_data[WIDTH-1]
//                         0: first bit lands in word_data[0]
//  Ports    : clk, rst (async, active-high)
//             clear            - discard the partial word (bit counter only)
//             bit_in/bit_valid - serial input and its qualifier
//             word_data/word_parity/word_valid/word_ready - output handshake
//             overflow         - sticky, a completed word was dropped
//             drop_count       - dropped words, saturating at 255
//  Revision : 1.0 - initial release
// ============================================================================
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_data,
    output logic             word_parity,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_done;      // one-cycle pulse: r_shift holds a full word
    logic [WIDTH-1:0] w_shift_nxt;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            // Shift left: the earliest bit ends up in the top position.
            assign w_shift_nxt = {r_shift[WIDTH-2:0], bit_in};
        end else begin : g_lsb_first
            // Shift right: the earliest bit ends up in bit 0.
            assign w_shift_nxt = {bit_in, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // The completed word is handed over one edge after its last bit is
    // sampled. r_shift still holds the whole word during the r_done cycle
    // even if a new bit shifts in on that same edge, because the output
    // register reads the pre-edge value. clear only zeroes the counter, so
    // a pending word survives a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_cnt <= '0;
            end else if (bit_valid) begin
                r_shift <= w_shift_nxt;
                if (r_cnt == c_LAST) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register state machine
    // ------------------------------------------------------------------
    slot_state_t r_state;
    slot_state_t w_state_nxt;
    logic        w_handshake;
    logic        w_load;
    logic        w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_handshake = (r_state == FULL) && word_ready;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (r_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (r_done) begin
                    // Same-cycle accept frees the slot for the new word;
                    // otherwise the held word wins and the new one is lost.
                    if (w_handshake) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (w_handshake) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output data, parity and drop bookkeeping
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_data;
    logic             r_parity;
    logic             r_overflow;
    logic [7:0]       r_drop_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_data   <= r_shift;
            r_parity <= parity_of(32'(r_shift));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != DROP_MAX) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign word_data   = r_data;
    assign word_parity = r_parity;
    assign word_valid  = (r_state == FULL);
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

endmodule : bit_packer
`default_nettype wire

// File: tb/tb_bit_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bit_packer
//  Purpose  : Self-checking bench for bit_packer. Two instances (MSB-first
//             and LSB-first) share one stimulus stream; a transaction-level
//             model (bit queue, one-word output slot, drop counter) supplies
//             the expected values, backed by directed constant checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_packer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         bit_in;
    logic         bit_valid;
    logic         word_ready;

    logic [W-1:0] data1, data0;
    logic         par1, par0, val1, val0, ovf1, ovf0;
    logic [7:0]   dc1, dc0;

    bit_packer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_data(data1), .word_parity(par1), .word_valid(val1), .word_ready(word_ready),
        .overflow(ovf1), .drop_count(dc1)
    );

    bit_packer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_data(data0), .word_parity(par0), .word_valid(val0), .word_ready(word_ready),
        .overflow(ovf0), .drop_count(dc0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit           m_bits[$];
    logic         m_valid, m_pend, m_ovf;
    logic [W-1:0] m_w1, m_w0, m_p1, m_p0;
    logic [7:0]   m_dc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par(input logic [W-1:0] w);
        return ($countones(w) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_valid = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_dc = 8'd0;
        m_w1 = '0; m_w0 = '0; m_p1 = '0; m_p0 = '0;
    endtask

    // One rising edge of the model: a word finished on the previous edge is
    // offered to the output slot now; the incoming bit then joins the queue.
    task automatic model_edge(input logic b, input logic v, input logic clr, input logic rdy);
        logic hs;
        hs = m_valid && rdy;
        if (m_pend) begin
            if (!m_valid || hs) begin
                m_w1 = m_p1; m_w0 = m_p0; m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
                if (m_dc < 8'd255) m_dc = m_dc + 8'd1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
        m_pend = 1'b0;
        if (clr) begin
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                m_p1 = '0; m_p0 = '0;
                for (int i = 0; i < W; i++) begin
                    m_p1 = (m_p1 << 1) | W'(m_bits[i]);
                    m_p0[i] = m_bits[i];
                end
                m_pend = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    task automatic compare_model();
        check("m_valid_msb", val1, m_valid);
        check("m_valid_lsb", val0, m_valid);
        check("m_ovf_msb", ovf1, m_ovf);
        check("m_ovf_lsb", ovf0, m_ovf);
        check("m_drop_msb", dc1, m_dc);
        check("m_drop_lsb", dc0, m_dc);
        if (m_valid) begin
            check("m_data_msb", data1, m_w1);
            check("m_par_msb", par1, par(m_w1));
            check("m_data_lsb", data0, m_w0);
            check("m_par_lsb", par0, par(m_w0));
        end
    endtask

    task automatic cycle(input logic b, input logic v, input logic clr, input logic rdy);
        @(negedge clk);
        bit_in = b; bit_valid = v; clear = clr; word_ready = rdy;
        @(posedge clk);
        model_edge(b, v, clr, rdy);
        #1;
        compare_model();
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 0; i--) cycle(w[i], 1'b1, 1'b0, rdy);
    endtask

    logic [7:0] c_basic;
    logic [7:0] c_clr;

    initial begin
        c_basic = 8'hB2;
        c_clr   = 8'hA7;
        rst = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        model_reset();
        #2;
        check("rst_valid", val1, 1'b0);
        check("rst_data", data1, 8'h00);
        check("rst_parity", par1, 1'b0);
        check("rst_overflow", ovf1, 1'b0);
        check("rst_drop", dc1, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic word: valid rises 9 cycles after the first bit, for 1 cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(c_basic[7-i], 1'b1, 1'b0, 1'b1);
            check("basic_not_yet", val1, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("basic_valid", val1, 1'b1);
        check("basic_data_msb", data1, 8'hB2);
        check("basic_par_msb", par1, 1'b0);
        check("basic_data_lsb", data0, 8'h4D);
        check("basic_par_lsb", par0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("basic_one_cycle", val1, 1'b0);

        // Accept and complete in the same cycle.
        send_word(8'h5A, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("simul_held", data1, 8'h5A);
        send_word(8'h3C, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("simul_valid", val1, 1'b1);
        check("simul_data", data1, 8'h3C);
        check("simul_no_ovf", ovf1, 1'b0);
        check("simul_no_drop", dc1, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("simul_drained", val1, 1'b0);

        // Overflow: two words dropped behind a stalled 8'hFF.
        send_word(8'hFF, 1'b0);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_data", data1, 8'hFF);
        check("ovf_parity", par1, 1'b0);
        check("ovf_flag", ovf1, 1'b1);
        check("ovf_drop", dc1, 8'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_accepted", val1, 1'b0);

        // Clear with bit_valid, then a gapped 8-bit word.
        for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            cycle(c_clr[i], 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("clr_valid", val1, 1'b1);
        check("clr_data_msb", data1, 8'hA7);
        check("clr_data_lsb", data0, 8'hE5);
        check("clr_keeps_ovf", ovf1, 1'b1);
        check("clr_keeps_drop", dc1, 8'd2);

        // Short asynchronous reset between edges, 6 bits into a word.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", val1, 1'b0);
        check("arst_data", data1, 8'h00);
        check("arst_parity", par1, 1'b0);
        check("arst_ovf", ovf1, 1'b0);
        check("arst_drop", dc1, 8'd0);
        check("arst_valid_lsb", val0, 1'b0);
        check("arst_drop_lsb", dc0, 8'd0);
        #1 rst = 1'b0;
        model_reset();
        send_word(8'hC3, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", val1, 1'b1);
        check("post_rst_data_msb", data1, 8'hC3);
        check("post_rst_data_lsb", data0, 8'hC3);
        check("post_rst_drop", dc1, 8'd0);
        check("post_rst_ovf", ovf1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back words with continuous valid and ready.
        for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bit_packer
`default_nettype wire
